// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared commands, frame geometry and FSM states for the SPI memory controller.
package spi_mem_pkg;
    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam int         XFER_BITS     = 40;
    localparam int         SPI_ADDR_W    = 24;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;
endpackage

// File: rtl/spi_mem_controller_if.sv
// spi_mem_controller_if: CPU request bus plus SPI pins; master = CPU/memory side, slave = controller.
interface spi_mem_controller_if #(parameter int ADDR_WIDTH = 16);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [7:0]            req_wdata;
    logic                  done;
    logic [7:0]            rdata;
    logic                  spi_clk;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_ce;
    modport master (output req_valid, req_we, req_addr, req_wdata, spi_miso,
                    input  req_ready, done, rdata, spi_clk, spi_mosi, spi_ce);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata, spi_miso,
                    output req_ready, done, rdata, spi_clk, spi_mosi, spi_ce);
endinterface

// File: rtl/spi_clk_phase.sv
// spi_clk_phase: CLK_DIV half-period divider; strobes mark the last cycle of each low/high half.
module spi_clk_phase #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_phase_rise,
    output logic o_phase_fall,
    output logic o_sample
);
    logic [7:0] r_cnt;
    logic       r_high;
    logic       w_last;
    assign w_last = (r_cnt == 8'(CLK_DIV - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_high <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_high <= 1'b0;
        end else if (w_last) begin
            r_cnt  <= '0;
            r_high <= ~r_high;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
    assign o_phase_rise = i_en & w_last & ~r_high;
    assign o_sample     = i_en & w_last & r_high;
    assign o_phase_fall = o_sample;
endmodule

// File: rtl/spi_mem_controller.sv
// spi_mem_controller: one CE-framed SPI transaction (CMD, 24-bit ADDR, one DATA byte) per request.
// Define SPI_MEM_WRITE_EN to enable the 0x02 write transaction; otherwise writes complete with no SPI activity.
module spi_mem_controller
    import spi_mem_pkg::*;
#(
    parameter int CLK_DIV    = 1,
    parameter int ADDR_WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    spi_mem_controller_if.slave bus
);
    state_t                r_state;
    logic [XFER_BITS-1:0]  r_shift;
    logic [2:0]            r_bit;
    logic [1:0]            r_byte;
    logic [7:0]            r_gap;
    logic [7:0]            r_rdata;
    logic                  r_ready, r_done, r_clk, r_mosi, r_ce, r_we;
    logic                  w_busy, w_rise, w_fall, w_sample, w_skip, w_last_bit;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [XFER_BITS-1:0]  w_frame;
    assign w_addr = bus.req_addr;
`ifdef SPI_MEM_WRITE_EN
    assign w_skip  = 1'b0;
    assign w_frame = bus.req_we ? {SPI_CMD_WRITE, SPI_ADDR_W'(w_addr), bus.req_wdata}
                                : {SPI_CMD_READ, SPI_ADDR_W'(w_addr), 8'h00};
`else
    assign w_skip  = bus.req_we;
    assign w_frame = {SPI_CMD_READ, SPI_ADDR_W'(w_addr), 8'h00};
`endif
    assign w_busy     = r_state inside {CMD, ADDR, DATA};
    assign w_last_bit = (r_bit == 3'd7);
    spi_clk_phase #(.CLK_DIV(CLK_DIV)) u_phase (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (w_busy),
        .o_phase_rise (w_rise),
        .o_phase_fall (w_fall),
        .o_sample     (w_sample)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_gap   <= '0;
            r_rdata <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_clk   <= 1'b0;
            r_mosi  <= 1'b0;
            r_ce    <= 1'b1;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    // a compiled-out write goes straight to a one-cycle GAP carrying done
                    r_state <= w_skip ? GAP : CMD;
                    r_ready <= 1'b0;
                    r_done  <= w_skip;
                    r_ce    <= w_skip;
                    r_mosi  <= ~w_skip & w_frame[XFER_BITS-1];
                    r_shift <= w_frame;
                    r_we    <= bus.req_we;
                    r_bit   <= '0;
                    r_byte  <= '0;
                    r_gap   <= '0;
                end
                CMD, ADDR, DATA: begin
                    if (w_rise) r_clk <= 1'b1;
                    if (w_fall) r_clk <= 1'b0;
                    if (w_sample) begin
                        // MISO enters at the LSB while MOSI leaves at the MSB
                        r_shift <= {r_shift[XFER_BITS-2:0], bus.spi_miso};
                        r_mosi  <= r_shift[XFER_BITS-2];
                        r_bit   <= r_bit + 3'd1;
                        if (w_last_bit && r_state == CMD) r_state <= ADDR;
                        if (w_last_bit && r_state == ADDR) begin
                            r_byte <= r_byte + 2'd1;
                            if (r_byte == 2'd2) r_state <= DATA;
                        end
                        if (w_last_bit && r_state == DATA) begin
                            r_state <= GAP;
                            r_ce    <= 1'b1;
                            r_done  <= 1'b1;
                            r_mosi  <= 1'b0;
                            r_gap   <= 8'(CLK_DIV - 1);
                            if (!r_we) r_rdata <= {r_shift[6:0], bus.spi_miso};
                        end
                    end
                end
                GAP: begin
                    r_done <= 1'b0;
                    if (r_gap == 8'd0) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_gap <= r_gap - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.req_ready = r_ready;
    assign bus.done      = r_done;
    assign bus.rdata     = r_rdata;
    assign bus.spi_clk   = r_clk;
    assign bus.spi_mosi  = r_mosi;
    assign bus.spi_ce    = r_ce;
endmodule

// File: tb/tb_spi_mem_controller.sv
// tb_spi_mem_controller: directed checks of spi_mem_controller with CLK_DIV=1 and CLK_DIV=3 instances.
module tb_spi_mem_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_mem_controller_if #(.ADDR_WIDTH(16)) b1 ();
    spi_mem_controller_if #(.ADDR_WIDTH(16)) b3 ();
    spi_mem_controller #(.CLK_DIV(1), .ADDR_WIDTH(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    spi_mem_controller #(.CLK_DIV(3), .ADDR_WIDTH(16)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000000: return 8'h3E;
            24'h000001: return 8'h03;
            24'h000002: return 8'h26;
            24'h000004: return 8'h2E;
            24'h00000A: return 8'h00;
            default:    return 8'hFF;
        endcase
    endfunction

    // serial memory models: collect MOSI on rising edges, drive data bits after edges 33..40
    logic [39:0] rx1, rx3;
    logic [23:0] a1, a3;
    logic [7:0]  mb1, mb3;
    int edges1 = 0, edges3 = 0, cefall1 = 0, cefall3 = 0;
    always @(negedge b1.spi_ce or posedge b1.spi_clk) begin
        if (!b1.spi_clk) begin
            edges1 = 0; rx1 = '0; cefall1++; b1.spi_miso = 1'b0;
        end else if (b1.spi_ce === 1'b0) begin
            rx1 = {rx1[38:0], b1.spi_mosi}; edges1++;
            if (edges1 == 32) a1 = rx1[23:0];
            if (edges1 >= 33) begin mb1 = mem_byte(a1); b1.spi_miso = mb1[40 - edges1]; end
        end
    end
    always @(negedge b3.spi_ce or posedge b3.spi_clk) begin
        if (!b3.spi_clk) begin
            edges3 = 0; rx3 = '0; cefall3++; b3.spi_miso = 1'b0;
        end else if (b3.spi_ce === 1'b0) begin
            rx3 = {rx3[38:0], b3.spi_mosi}; edges3++;
            if (edges3 == 32) a3 = rx3[23:0];
            if (edges3 >= 33) begin mb3 = mem_byte(a3); b3.spi_miso = mb3[40 - edges3]; end
        end
    end

    // spi_clk run lengths on the CLK_DIV=3 instance while CE is low
    int run3 = 0, rmin3 = 1000, rmax3 = 0;
    logic prev3 = 1'b0;
    always @(negedge clk) begin
        if (b3.spi_ce) begin
            run3 = 0; prev3 = 1'b0;
        end else if (b3.spi_clk === prev3) begin
            run3++;
        end else begin
            if (run3 < rmin3) rmin3 = run3;
            if (run3 > rmax3) rmax3 = run3;
            prev3 = b3.spi_clk; run3 = 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // returns the index T of the accepting posedge; leaves the caller at the negedge after T
    task automatic req(input bit sel, input logic we, input logic [15:0] a, input logic [7:0] wd, output int t);
        int n = 0;
        @(negedge clk);
        if (sel) begin b3.req_valid = 1'b1; b3.req_we = we; b3.req_addr = a; b3.req_wdata = wd; end
        else     begin b1.req_valid = 1'b1; b1.req_we = we; b1.req_addr = a; b1.req_wdata = wd; end
        while ((sel ? b3.req_ready : b1.req_ready) !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk("accept_timeout", 64'(n < 2000), 1);
        t = cyc + 1;
        @(negedge clk);
        if (sel) b3.req_valid = 1'b0; else b1.req_valid = 1'b0;
    endtask

    // rel = cycle of done relative to accept edge T
    task automatic wait_done(input bit sel, input int t, output int rel);
        int n = 0;
        while ((sel ? b3.done : b1.done) !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        chk("done_timeout", 64'(n < 3000), 1);
        rel = cyc + 1 - t;
    endtask

    initial begin
        int t, t1, t2, rel, hi, n, cf;
        b1.req_valid = 0; b1.req_we = 0; b1.req_addr = '0; b1.req_wdata = '0;
        b3.req_valid = 0; b3.req_we = 0; b3.req_addr = '0; b3.req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ce", b1.spi_ce, 1);
        chk("rst_clk", b1.spi_clk, 0);
        chk("rst_mosi", b1.spi_mosi, 0);
        chk("rst_ready", b1.req_ready, 1);
        chk("rst_done", b1.done, 0);
        chk("rst_rdata", b1.rdata, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        req(0, 0, 16'h0000, 8'h00, t);
        chk("rd0_ce_fall", b1.spi_ce, 0);
        chk("rd0_ready_low", b1.req_ready, 0);
        wait_done(0, t, rel);
        chk("rd0_done_time", rel, 81);
        chk("rd0_rdata", b1.rdata, 8'h3E);
        chk("rd0_ce_at_done", b1.spi_ce, 1);
        chk("rd0_clk_at_done", b1.spi_clk, 0);
        chk("rd0_ready_at_done", b1.req_ready, 0);
        chk("rd0_edges", edges1, 40);
        chk("rd0_mosi", rx1[39:8], 32'h0300_0000);
        @(negedge clk);
        chk("rd0_done_pulse", b1.done, 0);
        chk("rd0_ready_back", b1.req_ready, 1);

        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_addr = 16'h0001;
        t1 = cyc + 1;
        @(negedge clk);
        b1.req_addr = 16'h0002;
        wait_done(0, t1, rel);
        chk("b2b_first_rdata", b1.rdata, 8'h03);
        chk("b2b_first_mosi", rx1[39:8], 32'h0300_0001);
        hi = 0; n = 0; t2 = -1;
        while (b1.spi_ce !== 1'b0 && n < 100) begin
            hi++;
            if (b1.req_ready) t2 = cyc + 1;
            @(negedge clk); n++;
        end
        b1.req_valid = 1'b0;
        chk("b2b_ce_gap", hi, 2);
        chk("b2b_accept", t2 - t1, 82);
        wait_done(0, t2, rel);
        chk("b2b_second_time", rel, 81);
        chk("b2b_second_rdata", b1.rdata, 8'h26);
        @(negedge clk);

`ifdef SPI_MEM_WRITE_EN
        req(0, 1, 16'h1234, 8'hA5, t);
        wait_done(0, t, rel);
        chk("wr_done_time", rel, 81);
        chk("wr_rdata_kept", b1.rdata, 8'h26);
        chk("wr_mosi", rx1, 40'h02_0012_34A5);
        chk("wr_edges", edges1, 40);
`else
        cf = cefall1;
        req(0, 1, 16'h1234, 8'hA5, t);
        chk("wr_off_done", b1.done, 1);
        chk("wr_off_ce", b1.spi_ce, 1);
        chk("wr_off_ready_low", b1.req_ready, 0);
        @(negedge clk);
        chk("wr_off_ready", b1.req_ready, 1);
        chk("wr_off_done_pulse", b1.done, 0);
        chk("wr_off_no_ce", cefall1 - cf, 0);
        chk("wr_off_rdata_kept", b1.rdata, 8'h26);
`endif
        @(negedge clk);

        req(0, 0, 16'h0004, 8'h00, t);
        repeat (20) @(negedge clk);
        chk("rst_mid_busy", b1.spi_ce, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ce", b1.spi_ce, 1);
        chk("rst_mid_clk", b1.spi_clk, 0);
        chk("rst_mid_done", b1.done, 0);
        chk("rst_mid_rdata", b1.rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", b1.req_ready, 1);
        req(0, 0, 16'h0004, 8'h00, t);
        wait_done(0, t, rel);
        chk("rst_mid_rd_time", rel, 81);
        chk("rst_mid_rd_rdata", b1.rdata, 8'h2E);

        req(1, 0, 16'h00FF, 8'h00, t);
        wait_done(1, t, rel);
        chk("div3_pre_time", rel, 241);
        chk("div3_pre_rdata", b3.rdata, 8'hFF);
        @(negedge clk);
        req(1, 0, 16'h000A, 8'h00, t);
        wait_done(1, t, rel);
        chk("div3_done_time", rel, 241);
        chk("div3_rdata", b3.rdata, 8'h00);
        chk("div3_edges", edges3, 40);
        chk("div3_mosi", rx3[39:8], 32'h0300_000A);
        chk("div3_phase_min", rmin3, 3);
        chk("div3_phase_max", rmax3, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
